// File: rtl/strobe_seq_gen.sv
// Multi-channel strobe sequencer. Each channel waits out a delay and then emits
// a pulse train with a programmable width and gap, either a fixed number of pulses or continuously.
module strobe_seq_gen #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int REP_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         start,
  input  logic [N_CH-1:0]         stop,
  input  logic [N_CH*CNT_W-1:0]   cfg_delay,
  input  logic [N_CH*CNT_W-1:0]   cfg_width,
  input  logic [N_CH*CNT_W-1:0]   cfg_gap,
  input  logic [N_CH*REP_W-1:0]   cfg_count,
  output logic [N_CH-1:0]         strobe,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH-1:0]         done
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_HIGH, S_GAP} state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   width_q, width_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [REP_W-1:0]   pcnt_q, pcnt_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   width_m1, gap_m1;
    logic [REP_W:0]     pcnt_inc;
    logic               last_pulse;

    // A programmed width or gap of 0 behaves as 1 cycle.
    assign width_m1   = (width_q == '0) ? '0 : width_q - CNT_W'(1);
    assign gap_m1     = (gap_q == '0) ? '0 : gap_q - CNT_W'(1);
    assign pcnt_inc   = {1'b0, pcnt_q} + {{REP_W{1'b0}}, 1'b1};
    assign last_pulse = (rep_q != '0) && (pcnt_inc == {1'b0, rep_q});

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      width_d = width_q;
      gap_d   = gap_q;
      rep_d   = rep_q;
      pcnt_d  = pcnt_q;
      done_d  = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start[i] && !stop[i]) begin
            cnt_d   = cfg_delay[i*CNT_W +: CNT_W];
            width_d = cfg_width[i*CNT_W +: CNT_W];
            gap_d   = cfg_gap[i*CNT_W +: CNT_W];
            rep_d   = cfg_count[i*REP_W +: REP_W];
            pcnt_d  = '0;
            state_d = S_DELAY;
          end
        end
        S_DELAY: begin
          if (cnt_q == '0) begin
            state_d = S_HIGH;
            cnt_d   = width_m1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            // Saturates so continuous mode never wraps back into a match.
            pcnt_d = pcnt_inc[REP_W] ? pcnt_q : pcnt_inc[REP_W-1:0];
            if (last_pulse) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
              cnt_d   = gap_m1;
            end
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_d = S_HIGH;
            cnt_d   = width_m1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (stop[i] && (state_q != S_IDLE)) begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        width_q <= '0;
        gap_q   <= '0;
        rep_q   <= '0;
        pcnt_q  <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        width_q <= width_d;
        gap_q   <= gap_d;
        rep_q   <= rep_d;
        pcnt_q  <= pcnt_d;
        done_q  <= done_d;
      end
    end

    assign strobe[i] = (state_q == S_HIGH);
    assign busy[i]   = (state_q != S_IDLE);
    assign done[i]   = done_q;
  end

endmodule

// File: tb/tb_strobe_seq_gen.sv
// Directed bench for strobe_seq_gen: per-edge expected strobe/busy/done vectors,
// bit k of each vector being the value just after edge Ek.
module tb_strobe_seq_gen;
  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int REP_W = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH-1:0]       start = '0;
  logic [N_CH-1:0]       stop  = '0;
  logic [N_CH*CNT_W-1:0] cfg_delay = '0;
  logic [N_CH*CNT_W-1:0] cfg_width = '0;
  logic [N_CH*CNT_W-1:0] cfg_gap   = '0;
  logic [N_CH*REP_W-1:0] cfg_count = '0;
  logic [N_CH-1:0]       strobe, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  strobe_seq_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width), .cfg_gap(cfg_gap), .cfg_count(cfg_count),
    .strobe(strobe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ch, input int d, input int w, input int g, input int c);
    cfg_delay[ch*CNT_W +: CNT_W] = CNT_W'(d);
    cfg_width[ch*CNT_W +: CNT_W] = CNT_W'(w);
    cfg_gap[ch*CNT_W +: CNT_W]   = CNT_W'(g);
    cfg_count[ch*REP_W +: REP_W] = REP_W'(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start on ch for edge E0, then checks outputs after E0..En.
  task automatic run_seq(input string tag, input int ch, input int n,
                         input logic [31:0] es, input logic [31:0] eb, input logic [31:0] ed);
    start[ch] = 1'b1;
    step();
    start[ch] = 1'b0;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) step();
      check($sformatf("%s strobe E%0d", tag, k), 32'(strobe[ch]), 32'(es[k]));
      check($sformatf("%s busy E%0d", tag, k),   32'(busy[ch]),   32'(eb[k]));
      check($sformatf("%s done E%0d", tag, k),   32'(done[ch]),   32'(ed[k]));
    end
  endtask

  initial begin
    #2;
    check("reset strobe", 32'(strobe), 32'h0);
    check("reset busy",   32'(busy),   32'h0);
    check("reset done",   32'(done),   32'h0);
    #10 rst = 1'b0;
    step();

    // Single one-cycle pulse
    set_cfg(0, 0, 1, 0, 1);
    run_seq("t1", 0, 3, 32'b0010, 32'b0011, 32'b0100);

    // delay=3 width=2 gap=1 count=3
    set_cfg(0, 3, 2, 1, 3);
    run_seq("t2", 0, 12, 32'b0110110110000, 32'b0111111111111, 32'b1000000000000);

    // Continuous mode, stop sampled at E20
    set_cfg(0, 0, 2, 2, 0);
    run_seq("t3", 0, 19, 32'h66666, 32'hFFFFF, 32'h0);
    stop[0] = 1'b1;
    step();
    stop[0] = 1'b0;
    check("t3 strobe after stop", 32'(strobe[0]), 32'h0);
    check("t3 busy after stop",   32'(busy[0]),   32'h0);
    check("t3 done after stop",   32'(done[0]),   32'h0);
    step();
    check("t3 no late done", 32'(done[0]), 32'h0);
    set_cfg(0, 0, 1, 0, 1);
    run_seq("t3 restart", 0, 3, 32'b0010, 32'b0011, 32'b0100);

    // Zero width/gap behave as one cycle
    set_cfg(0, 0, 0, 0, 2);
    run_seq("t4", 0, 5, 32'b001010, 32'b001111, 32'b010000);

    // Two channels started together; ch0 cfg and start disturbed mid-run
    set_cfg(0, 1, 1, 2, 2);
    set_cfg(1, 0, 3, 1, 1);
    start[1:0] = 2'b11;
    step();
    start[1:0] = 2'b00;
    for (int k = 0; k <= 7; k++) begin
      logic [7:0] s0, b0, d0, s1, b1, d1;
      s0 = 8'b00100100; b0 = 8'b00111111; d0 = 8'b01000000;
      s1 = 8'b00001110; b1 = 8'b00001111; d1 = 8'b00010000;
      if (k > 0) step();
      check($sformatf("t5 ch0 strobe E%0d", k), 32'(strobe[0]), 32'(s0[k]));
      check($sformatf("t5 ch0 busy E%0d", k),   32'(busy[0]),   32'(b0[k]));
      check($sformatf("t5 ch0 done E%0d", k),   32'(done[0]),   32'(d0[k]));
      check($sformatf("t5 ch1 strobe E%0d", k), 32'(strobe[1]), 32'(s1[k]));
      check($sformatf("t5 ch1 busy E%0d", k),   32'(busy[1]),   32'(b1[k]));
      check($sformatf("t5 ch1 done E%0d", k),   32'(done[1]),   32'(d1[k]));
      if (k == 2) begin
        set_cfg(0, 0, 7, 7, 0);
        start[0] = 1'b1;
      end else begin
        start[0] = 1'b0;
      end
    end

    // Held start re-triggers on the edge after done rises
    set_cfg(2, 0, 1, 0, 1);
    start[2] = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      logic [3:0] eb, ed;
      eb = 4'b1011; ed = 4'b0100;
      step();
      check($sformatf("t7 busy E%0d", k), 32'(busy[2]), 32'(eb[k]));
      check($sformatf("t7 done E%0d", k), 32'(done[2]), 32'(ed[k]));
    end
    start[2] = 1'b0;
    stop[2] = 1'b1;
    step();
    stop[2] = 1'b0;
    check("t7 stopped", 32'(busy[2]), 32'h0);

    // Async reset while ch0 is HIGH and ch1 is showing done
    set_cfg(0, 0, 4, 0, 1);
    set_cfg(1, 0, 1, 0, 1);
    start[1:0] = 2'b11;
    step();
    start[1:0] = 2'b00;
    step();
    step();
    check("t6 pre strobe0", 32'(strobe[0]), 32'h1);
    check("t6 pre done1",   32'(done[1]),   32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6 rst strobe", 32'(strobe), 32'h0);
    check("t6 rst busy",   32'(busy),   32'h0);
    check("t6 rst done",   32'(done),   32'h0);
    #3 rst = 1'b0;
    step();
    check("t6 idle after rst", 32'(busy), 32'h0);

    // start with stop in IDLE
    set_cfg(0, 0, 1, 0, 1);
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    step();
    start[0] = 1'b0;
    stop[0]  = 1'b0;
    check("t6 start+stop busy", 32'(busy[0]), 32'h0);
    step();
    check("t6 start+stop strobe", 32'(strobe[0]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/strobe_seq_gen.md
# strobe_seq_gen

Synthesizable, parametrised multi-channel strobe sequencer and the hardware successor to the `gen_strobe` testbench task. Each channel runs a delay, then a train of pulses with programmable width and gap, either a fixed number of pulses or continuously until stopped. The block drives register-programmed strobes and sync pulses toward the ADV7393 datapath and bench stimulus in the AXI video design. Channels are fully independent and share only clock and reset.

## Interface
- N_CH, 4: number of independent channels
- CNT_W, 16: width of delay/width/gap counters
- REP_W, 8: width of pulse-repeat count
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  N_CH  per-channel start request, sampled each edge
- stop  in  N_CH  per-channel abort request, sampled each edge
- cfg_delay  in  N_CH*CNT_W  channel i at [i*CNT_W +: CNT_W]; idle cycles before first pulse
- cfg_width  in  N_CH*CNT_W  pulse high time in cycles; 0 treated as 1
- cfg_gap  in  N_CH*CNT_W  low time between pulses; 0 treated as 1
- cfg_count  in  N_CH*REP_W  channel i at [i*REP_W +: REP_W]; pulses per sequence; 0 = continuous
- strobe  out  N_CH  registered pulse output
- busy  out  N_CH  high while the channel is not IDLE
- done  out  N_CH  one-cycle pulse on natural completion

## Operation
- Per-channel FSM states: IDLE, DELAY, HIGH, GAP. `strobe` is high exactly when the state is HIGH. `busy` is high when the state is not IDLE. Both are derived from registered state, with no combinational path from inputs.
- IDLE, start=1, stop=0: latch all four cfg fields into channel shadow registers, load cnt=delay, go to DELAY. The cfg inputs are ignored afterwards until the channel is IDLE again.
- DELAY: if cnt==0, go to HIGH and load cnt=max(width,1)-1. Otherwise decrement cnt. DELAY lasts delay+1 cycles.
- HIGH: if cnt!=0, decrement. If cnt==0:
  - If this is the last pulse (pulses emitted == count, count!=0): go to IDLE and assert done for one cycle.
  - Otherwise go to GAP and load cnt=max(gap,1)-1.
- GAP: if cnt==0, go to HIGH and reload the width. Otherwise decrement.
- Pulse counter: REP_W bits, incremented on each HIGH exit. In continuous mode it saturates and is never compared.
- stop=1 in any non-IDLE state: go to IDLE on that edge. No done is generated. stop overrides every other transition.
- start while not IDLE is ignored. start and stop on the same edge in IDLE leaves the channel in IDLE.
- start held high continuously re-triggers on the first edge the channel is IDLE, so the earliest re-trigger is the edge after done rises.
- Reset (asynchronous, any time): all states IDLE; strobe, busy, done, counters and shadow registers clear to 0. Outputs go low immediately when rst asserts, without waiting for a clock edge.

## Timing
- Let E0 be the edge sampling start. States change on E0.
- busy rises after E0.
- strobe first rises after edge E0+delay+1.
- Each pulse is high for max(width,1) cycles and low for max(gap,1) cycles between pulses.
- With count=N, strobe falls for the last time after edge E0+delay+1+N·w+(N−1)·g, where w=max(width,1) and g=max(gap,1).
- On that same edge: busy falls and done rises; done falls after the next edge.
- stop sampled at edge Es: strobe and busy are low after Es.
- Channels have no cross-coupling; simultaneous starts produce independent timelines.

## Test plan
- Ch0, delay=0, width=1, count=1, start at E0 → strobe high between E1 and E2 only; done high between E2 and E3; busy high E0→E2.
- Ch0, delay=3, width=2, gap=1, count=3 → strobe high after E4, E5, E7, E8, E10, E11 and low after E6 and E9; done after E12, exactly 3 pulses.
- count=0, width=2, gap=2, stop asserted at edge E20 → strobe and busy low after E20; no done pulse; the following start restarts normally.
- width=0, gap=0, count=2, delay=0 → strobe pattern 1,0,1 after E1..E3; done after E4.
- Ch0 and ch1 started on the same edge with different configs → each matches its own expected timeline. Change cfg and pulse start mid-sequence → no effect on the running channel.
- Assert rst asynchronously during HIGH → strobe, busy and done go low before the next edge. After release, start together with stop in IDLE → channel stays IDLE.
